ahb_traffic_gen: RTL and testbench
==================================

# ahb_traffic_gen

Synthesizable, parametrised AHB-Lite master stimulus engine. It replaces the task-driven AHB master model in the bridge bench, and can also sit on-chip as a bring-up traffic source in front of `Bridge_top`. One `start` command issues a single or incrementing-burst write or read of programmable length, with a generated data pattern. With the checker compiled in, it self-checks read data against the same pattern.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width (multiple of 8); address step per beat is `DATA_W/8`.
- `MAX_BEATS`, 16, maximum burst length; `BW = $clog2(MAX_BEATS)+1`.

Ports:
- `hclk` in 1: single clock, rising edge.
- `hresetn` in 1: asynchronous, active-low reset.
- `start` in 1: command strobe, sampled only in IDLE.
- `mode` in 2: command type.
  - 00 single write
  - 01 burst write
  - 10 single read
  - 11 burst read
- `beats` in BW: burst length, sampled with `start`.
- `start_addr` in ADDR_W: first beat address.
- `seed` in DATA_W: pattern base; beat i carries `seed + i` (modulo 2^DATA_W).
- `hreadyout` in 1: slave ready.
- `hrdata` in DATA_W: slave read data.
- `hresp` in 2: slave response; 2'b01 = ERROR.
- `haddr` out ADDR_W, `hwdata` out DATA_W, `hwrite` out 1, `htrans` out 2: AHB master outputs.
- `hreadyin` out 1: 1 whenever out of reset.
- `rd_data` out DATA_W, `rd_valid` out 1: captured read beat.
- `busy` out 1, `done` out 1 (one-cycle pulse), `err` out 1 (sticky until next accepted `start`).
- `mismatch_cnt` out 8: saturating count of read miscompares.

## Operation
- FSM states and transitions:
  - IDLE: `start`=1 latches the command; next state ADDR.
  - ADDR: first address phase, `htrans`=NONSEQ (2'b10), `haddr`=`start_addr`.
  - BURST: overlapped address and data phases, `htrans`=SEQ (2'b11).
  - LAST: data phase of the final beat, `htrans`=IDLE (2'b00).
  - DONE: `done`=1 for one cycle; return to IDLE.
- Effective length:
  - Single modes: 1 beat, regardless of `beats`.
  - Burst modes: `beats`=0 runs as 1 beat; `beats`>`MAX_BEATS` is clamped to `MAX_BEATS`.
- Address: beat i uses `start_addr + i*(DATA_W/8)`, wrapping modulo 2^ADDR_W. No 1 KB boundary split.
- `hwrite` is held constant for the whole command.
- Write data: `hwdata`=`seed+i` in the data phase of beat i; holds its value otherwise.
- Read data: each data phase completing with `hreadyout`=1 registers `rd_data`=`hrdata` and pulses `rd_valid` for one cycle.
- Wait states: while `hreadyout`=0, `haddr`, `htrans`, `hwrite` and `hwdata` hold, and the beat counter does not advance.
- ERROR response: `hresp`=2'b01 seen in any data phase:
  - `err`=1.
  - `htrans`=IDLE from the next cycle; remaining beats are dropped.
  - Go to DONE.
- `start` while `busy`=1 is ignored; no queuing.
- `busy`=1 from the cycle after `start` is accepted through the DONE cycle inclusive.

## Timing
- Reset values, applied immediately and asynchronously:
  - `haddr`=0, `hwdata`=0, `hwrite`=0, `htrans`=2'b00, `hreadyin`=0.
  - `rd_data`=0, `rd_valid`=0, `busy`=0, `done`=0, `err`=0, `mismatch_cnt`=0.
  - FSM in IDLE.
- Reset in mid-burst aborts the burst with no `done` pulse.
- Start latency: `start` high at edge T gives NONSEQ on the bus during cycle T+1.
- Zero-wait N-beat burst: address phases occupy cycles T+1..T+N; data phases T+2..T+N+1; `done` in cycle T+N+2.
- Each wait state adds exactly one cycle to all later events.
- `rd_valid` is asserted the cycle after the completing data phase.
- Back-to-back commands: earliest next `start` acceptance is in the cycle after DONE. Minimum one IDLE bus cycle between commands.

## Configuration
- `AHB_TRAFFIC_CHECK_EN` defined:
  - Each read beat is compared to `seed+i`.
  - On a miscompare: `mismatch_cnt` increments (saturates at 255) and `err`=1.
  - `mismatch_cnt` clears on the next accepted `start`.
- `AHB_TRAFFIC_CHECK_EN` undefined:
  - No comparator is built.
  - `mismatch_cnt` is tied to 0.
  - `err` is set only by an `hresp` ERROR.

## Test plan
- Reset, then single write (mode 00) to 0x8000_0000, seed 0xA5A5_0000:
  - NONSEQ at T+1 and `hwdata`=0xA5A5_0000 at T+2.
  - `done` at T+3; `err`=0.
- Burst write (mode 01) of 4 beats from 0x8000_0010, seed 0x10:
  - Addresses 0x10, 0x14, 0x18, 0x1C with NONSEQ, SEQ, SEQ, SEQ.
  - `hwdata` 0x10..0x13; `done` at T+6.
- Burst read (mode 11) of 8 beats with `hreadyout` low for 2 cycles on beat 3:
  - Bus outputs hold during the stall.
  - 8 `rd_valid` pulses; `done` at T+12.
- Burst read with slave returning seed+i except beat 2 corrupted, checker compiled in:
  - `mismatch_cnt`=1, `err`=1.
  - With the macro undefined: `mismatch_cnt`=0, `err`=0.
- Burst write of 6 beats with `hresp`=2'b01 in the data phase of beat 2:
  - `htrans`=IDLE next cycle.
  - `err`=1, `done` pulses, no further beats issued.
- Edge cases:
  - `beats`=0 in mode 01 runs 1 beat.
  - `beats`=31 runs 16 beats.
  - `start_addr`=0xFFFF_FFFC burst of 2 gives addresses 0xFFFF_FFFC then 0x0.
  - `hresetn` pulsed low mid-burst: all outputs return to reset values at once, with no `done`.

Source files
------------

// File: rtl/ahb_traffic_gen.sv
// AHB-Lite master traffic source: single or INCR burst read/write carrying a seed+i data pattern.
// Defining AHB_TRAFFIC_CHECK_EN builds the read-data comparator and mismatch counter.
module ahb_traffic_gen #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 16,
   localparam int BW       = $clog2(MAX_BEATS) + 1
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [BW-1:0]     beats,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [DATA_W-1:0] seed,
   input  logic              hreadyout,
   input  logic [DATA_W-1:0] hrdata,
   input  logic [1:0]        hresp,
   output logic [ADDR_W-1:0] haddr,
   output logic [DATA_W-1:0] hwdata,
   output logic              hwrite,
   output logic [1:0]        htrans,
   output logic              hreadyin,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        mismatch_cnt,
   output logic [2:0]        dbg_state_o
);

   localparam logic [ADDR_W-1:0] ADDR_STEP     = ADDR_W'(DATA_W / 8);
   localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0]        HTRANS_SEQ    = 2'b11;
   localparam logic [1:0]        HRESP_ERROR   = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_BURST = 3'd2,
      S_LAST  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   haddr_q, haddr_d;
   logic [DATA_W-1:0]   hwdata_q, hwdata_d;
   logic                hwrite_q, hwrite_d;
   logic [1:0]          htrans_q, htrans_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                err_q, err_d;
   logic [BW-1:0]       cnt_q, cnt_d;
   logic [BW-1:0]       len_q, len_d;
   logic [DATA_W-1:0]   seed_q, seed_d;
   logic [BW-1:0]       eff_len;
   logic                data_phase;
   logic                resp_err;
   logic                rd_beat;
   logic                miscmp;

   // Transfer handshake: an address phase is accepted, and a data phase completes, on a rising
   // edge where hreadyout=1; while hreadyout=0 every master output holds.
   assign data_phase = (state_q == S_BURST) || (state_q == S_LAST);
   assign resp_err   = (hresp == HRESP_ERROR);
   assign rd_beat    = data_phase && !resp_err && hreadyout && !hwrite_q;

   // Single modes always run one beat; bursts map 0 to 1 and clamp at MAX_BEATS.
   always_comb begin
      eff_len = BW'(1);
      if (mode[0]) begin
         if (beats == '0) begin
            eff_len = BW'(1);
         end else if (beats > BW'(MAX_BEATS)) begin
            eff_len = BW'(MAX_BEATS);
         end else begin
            eff_len = beats;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      haddr_d    = haddr_q;
      hwdata_d   = hwdata_q;
      hwrite_d   = hwrite_q;
      htrans_d   = htrans_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      err_d      = err_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      seed_d     = seed_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_ADDR;
               haddr_d  = start_addr;
               htrans_d = HTRANS_NONSEQ;
               hwrite_d = ~mode[1];
               len_d    = eff_len;
               seed_d   = seed;
               cnt_d    = '0;
               err_d    = 1'b0;
            end
         end
         S_ADDR: begin
            if (hreadyout) begin
               cnt_d = BW'(1);
               if (hwrite_q) hwdata_d = seed_q;
               if (len_q == BW'(1)) begin
                  htrans_d = HTRANS_IDLE;
                  state_d  = S_LAST;
               end else begin
                  htrans_d = HTRANS_SEQ;
                  haddr_d  = haddr_q + ADDR_STEP;
                  state_d  = S_BURST;
               end
            end
         end
         S_BURST, S_LAST: begin
            if (resp_err) begin
               err_d    = 1'b1;
               htrans_d = HTRANS_IDLE;
               state_d  = S_DONE;
            end else if (hreadyout) begin
               if (rd_beat) begin
                  rd_data_d  = hrdata;
                  rd_valid_d = 1'b1;
                  if (miscmp) err_d = 1'b1;
               end
               if (state_q == S_LAST) begin
                  state_d = S_DONE;
               end else begin
                  // cnt_q is the beat in the address phase; its data phase starts next cycle.
                  cnt_d = cnt_q + BW'(1);
                  if (hwrite_q) hwdata_d = seed_q + DATA_W'(cnt_q);
                  if (cnt_q + BW'(1) == len_q) begin
                     htrans_d = HTRANS_IDLE;
                     state_d  = S_LAST;
                  end else begin
                     haddr_d = haddr_q + ADDR_STEP;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q    <= S_IDLE;
         haddr_q    <= '0;
         hwdata_q   <= '0;
         hwrite_q   <= 1'b0;
         htrans_q   <= HTRANS_IDLE;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         len_q      <= '0;
         seed_q     <= '0;
      end else begin
         state_q    <= state_d;
         haddr_q    <= haddr_d;
         hwdata_q   <= hwdata_d;
         hwrite_q   <= hwrite_d;
         htrans_q   <= htrans_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         seed_q     <= seed_d;
      end
   end

`ifdef AHB_TRAFFIC_CHECK_EN
   logic [DATA_W-1:0] exp_data;
   logic [7:0]        mis_q, mis_d;

   // During a data phase the completing beat index is cnt_q-1.
   assign exp_data = seed_q + DATA_W'(cnt_q - BW'(1));
   assign miscmp   = (hrdata != exp_data);

   always_comb begin
      mis_d = mis_q;
      if ((state_q == S_IDLE) && start) begin
         mis_d = '0;
      end else if (rd_beat && miscmp && (mis_q != 8'hFF)) begin
         mis_d = mis_q + 8'd1;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) mis_q <= '0;
      else          mis_q <= mis_d;
   end

   assign mismatch_cnt = mis_q;
`else
   assign miscmp       = 1'b0;
   assign mismatch_cnt = 8'h00;
`endif

   assign haddr       = haddr_q;
   assign hwdata      = hwdata_q;
   assign hwrite      = hwrite_q;
   assign htrans      = htrans_q;
   assign hreadyin    = hresetn;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_traffic_gen.sv
// Bench for ahb_traffic_gen: reactive AHB slave plus scoreboard queues for address phases,
// write data and captured read data.
module tb_ahb_traffic_gen;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BW     = 5;

   logic              hclk = 1'b0;
   logic              hresetn = 1'b1;
   logic              start = 1'b0;
   logic [1:0]        mode = 2'b00;
   logic [BW-1:0]     beats = '0;
   logic [ADDR_W-1:0] start_addr = '0;
   logic [DATA_W-1:0] seed = '0;
   logic              hreadyout = 1'b1;
   logic [DATA_W-1:0] hrdata = '0;
   logic [1:0]        hresp = 2'b00;
   logic [ADDR_W-1:0] haddr;
   logic [DATA_W-1:0] hwdata;
   logic              hwrite;
   logic [1:0]        htrans;
   logic              hreadyin;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              busy;
   logic              done;
   logic              err;
   logic [7:0]        mismatch_cnt;
   logic [2:0]        dbg_state;

   ahb_traffic_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(16)) dut (
      .hclk(hclk), .hresetn(hresetn), .start(start), .mode(mode), .beats(beats),
      .start_addr(start_addr), .seed(seed), .hreadyout(hreadyout), .hrdata(hrdata),
      .hresp(hresp), .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans),
      .hreadyin(hreadyin), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
      .done(done), .err(err), .mismatch_cnt(mismatch_cnt), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 hclk = ~hclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   logic [34:0] exp_a_q[$];   // {hwrite, htrans, haddr}
   logic [31:0] exp_w_q[$];
   logic [31:0] exp_r_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- slave model + monitor ----------------
   bit          mon_en = 1'b1;
   bit          cur_write = 1'b0;
   bit          dp_prev = 1'b0, acc_prev = 1'b0, rdy_prev = 1'b1, dp_now = 1'b0, err_now = 1'b0;
   int          dbeat = 0, stall_left = 0;
   int          sl_stall_beat = -1, sl_err_beat = -1, sl_corrupt_beat = -1;
   logic [31:0] sl_rseed = '0;
   logic [34:0] a_tmp;
   logic [31:0] d_tmp;

   initial begin
      forever begin
         @(negedge hclk);
         if (!hresetn) begin
            dp_prev = 1'b0; acc_prev = 1'b0; rdy_prev = 1'b1;
            hreadyout = 1'b1; hresp = 2'b00; hrdata = '0;
         end else begin
            dp_now    = acc_prev || (dp_prev && !rdy_prev);
            hreadyout = 1'b1;
            hresp     = 2'b00;
            hrdata    = '0;
            if (dp_now) begin
               if (dbeat == sl_stall_beat && stall_left > 0) begin
                  hreadyout = 1'b0;
                  stall_left--;
               end
               if (dbeat == sl_err_beat) hresp = 2'b01;
               hrdata = sl_rseed + 32'(dbeat);
               if (dbeat == sl_corrupt_beat) hrdata = hrdata ^ 32'h0000_0F00;
            end
            err_now = dp_now && (hresp == 2'b01);
            if (mon_en) begin
               if (htrans[1]) begin
                  if (exp_a_q.size() == 0) begin
                     check("addr_unexpected", 64'(exp_a_q.size()), 64'd1);
                  end else begin
                     check("addr_phase", 64'({hwrite, htrans, haddr}), 64'(exp_a_q[0]));
                     if (hreadyout && !err_now) a_tmp = exp_a_q.pop_front();
                  end
               end
               if (dp_now && cur_write) begin
                  if (exp_w_q.size() == 0) begin
                     check("wdata_unexpected", 64'(exp_w_q.size()), 64'd1);
                  end else begin
                     check("wdata", 64'(hwdata), 64'(exp_w_q[0]));
                     if (hreadyout) d_tmp = exp_w_q.pop_front();
                  end
               end
               if (rd_valid) begin
                  if (exp_r_q.size() == 0) begin
                     check("rdata_unexpected", 64'(exp_r_q.size()), 64'd1);
                  end else begin
                     d_tmp = exp_r_q.pop_front();
                     check("rd_data", 64'(rd_data), 64'(d_tmp));
                  end
               end
            end
            if (dp_now && hreadyout && !err_now) dbeat++;
            acc_prev = htrans[1] && hreadyout && !err_now;
            dp_prev  = dp_now && !err_now;
            rdy_prev = hreadyout;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_cmd(input string tag, input logic [1:0] m, input logic [BW-1:0] b,
                          input logic [31:0] a, input logic [31:0] s, input int stall_beat,
                          input int stall_n, input int err_beat, input int corrupt_beat,
                          input bit poke, input logic exp_err, input logic [7:0] exp_mis);
      int n, n_addr, n_wr, n_rd, left, exp_done, cyc, k;
      logic [31:0] v;
      n = !m[0] ? 1 : (b == '0) ? 1 : (int'(b) > 16) ? 16 : int'(b);
      if (err_beat >= 0) begin
         n_addr   = (err_beat + 1 < n) ? err_beat + 2 : n;
         left     = (err_beat + 1 < n) ? 1 : 0;
         n_wr     = err_beat + 1;
         n_rd     = err_beat;
         exp_done = err_beat + 3 + stall_n;
      end else begin
         n_addr   = n;
         left     = 0;
         n_wr     = n;
         n_rd     = n;
         exp_done = n + 2 + stall_n;
      end
      for (int i = 0; i < n_addr; i++)
         exp_a_q.push_back({~m[1], (i == 0) ? 2'b10 : 2'b11, a + 32'(4 * i)});
      if (!m[1]) begin
         for (int i = 0; i < n_wr; i++) exp_w_q.push_back(s + 32'(i));
      end else begin
         for (int i = 0; i < n_rd; i++) begin
            v = s + 32'(i);
            if (i == corrupt_beat) v = v ^ 32'h0000_0F00;
            exp_r_q.push_back(v);
         end
      end

      k = 0;
      while (busy && k < 100) begin
         @(negedge hclk);
         k++;
      end
      if (busy) check({tag, "_idle_wait"}, 64'(busy), 64'd0);

      cur_write       = ~m[1];
      sl_stall_beat   = stall_beat;
      stall_left      = stall_n;
      sl_err_beat     = err_beat;
      sl_corrupt_beat = corrupt_beat;
      sl_rseed        = s;
      dbeat           = 0;
      start = 1'b1; mode = m; beats = b; start_addr = a; seed = s;
      @(negedge hclk);
      start = 1'b0;
      cyc   = 1;
      check({tag, "_busy_t1"}, 64'(busy), 64'd1);
      while (!done && cyc < 100) begin
         @(negedge hclk);
         cyc++;
         if (poke) start = (cyc == 3);
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
      check({tag, "_htrans_in_done"}, 64'(htrans), 64'd0);
      check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
      check({tag, "_err"}, 64'(err), 64'(exp_err));
      check({tag, "_mismatch_cnt"}, 64'(mismatch_cnt), 64'(exp_mis));
      @(negedge hclk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check({tag, "_htrans_after"}, 64'(htrans), 64'd0);
      check({tag, "_addr_left"}, 64'(exp_a_q.size()), 64'(left));
      check({tag, "_wdata_left"}, 64'(exp_w_q.size()), 64'd0);
      check({tag, "_rdata_left"}, 64'(exp_r_q.size()), 64'd0);
      exp_a_q.delete();
      exp_w_q.delete();
      exp_r_q.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_haddr"}, 64'(haddr), 64'd0);
      check({tag, "_hwdata"}, 64'(hwdata), 64'd0);
      check({tag, "_hwrite"}, 64'(hwrite), 64'd0);
      check({tag, "_htrans"}, 64'(htrans), 64'd0);
      check({tag, "_hreadyin"}, 64'(hreadyin), 64'd0);
      check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
      check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_mismatch"}, 64'(mismatch_cnt), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int rm, rb, eff, sb, sn;
      logic [31:0] ra, rs;

      #3 hresetn = 1'b0;
      #10;
      check_reset_values("reset");
      @(negedge hclk);
      hresetn = 1'b1;
      @(negedge hclk);
      check("hreadyin_out_of_reset", 64'(hreadyin), 64'd1);

      run_cmd("single_wr", 2'b00, 5'd0, 32'h8000_0000, 32'hA5A5_0000, -1, 0, -1, -1, 1'b0, 1'b0, 8'd0);
      run_cmd("burst_wr4", 2'b01, 5'd4, 32'h8000_0010, 32'h0000_0010, -1, 0, -1, -1, 1'b0, 1'b0, 8'd0);
      run_cmd("burst_rd8_stall", 2'b11, 5'd8, 32'h2000_0100, 32'h1234_5600, 3, 2, -1, -1, 1'b1, 1'b0, 8'd0);
`ifdef AHB_TRAFFIC_CHECK_EN
      run_cmd("rd_corrupt", 2'b11, 5'd4, 32'h3000_0000, 32'h5555_0000, -1, 0, -1, 2, 1'b0, 1'b1, 8'd1);
`else
      run_cmd("rd_corrupt", 2'b11, 5'd4, 32'h3000_0000, 32'h5555_0000, -1, 0, -1, 2, 1'b0, 1'b0, 8'd0);
`endif
      run_cmd("wr_error", 2'b01, 5'd6, 32'h4000_0000, 32'h0BAD_0000, -1, 0, 2, -1, 1'b0, 1'b1, 8'd0);
      run_cmd("beats0", 2'b01, 5'd0, 32'h5000_0000, 32'h0000_00E0, -1, 0, -1, -1, 1'b0, 1'b0, 8'd0);
      run_cmd("beats31", 2'b01, 5'd31, 32'h6000_0000, 32'hFFFF_FFF8, -1, 0, -1, -1, 1'b0, 1'b0, 8'd0);
      run_cmd("addr_wrap", 2'b01, 5'd2, 32'hFFFF_FFFC, 32'h0000_0777, -1, 0, -1, -1, 1'b0, 1'b0, 8'd0);
      run_cmd("single_rd", 2'b10, 5'd7, 32'h7000_0040, 32'hCAFE_0000, -1, 0, -1, -1, 1'b0, 1'b0, 8'd0);

      for (int i = 0; i < 4; i++) begin
         rm  = int'($urandom_range(0, 3));
         rb  = int'($urandom_range(1, 16));
         eff = (rm % 2 == 1) ? rb : 1;
         sb  = int'($urandom_range(0, eff - 1));
         sn  = int'($urandom_range(0, 3));
         ra  = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
         rs  = $urandom();
         run_cmd("random", 2'(rm), BW'(rb), ra, rs, sb, sn, -1, -1, 1'b0, 1'b0, 8'd0);
      end

      // Reset in the middle of a read burst.
      mon_en = 1'b0;
      sl_stall_beat = -1; stall_left = 0; sl_err_beat = -1; sl_corrupt_beat = -1;
      sl_rseed = 32'h0000_7700; dbeat = 0;
      start = 1'b1; mode = 2'b11; beats = 5'd8; start_addr = 32'h0900_0000; seed = 32'h0000_7700;
      @(negedge hclk);
      start = 1'b0;
      repeat (4) @(negedge hclk);
      check("mid_rst_busy_before", 64'(busy), 64'd1);
      check("mid_rst_rdvalid_before", 64'(rd_valid), 64'd1);
      #2 hresetn = 1'b0;
      #1;
      check_reset_values("mid_rst");
      for (int i = 0; i < 3; i++) begin
         @(negedge hclk);
         check("mid_rst_no_done", 64'(done), 64'd0);
      end
      hresetn = 1'b1;
      exp_a_q.delete();
      exp_w_q.delete();
      exp_r_q.delete();
      @(negedge hclk);
      mon_en = 1'b1;

      run_cmd("after_rst", 2'b01, 5'd3, 32'h0A00_0000, 32'h0000_0100, 1, 1, -1, -1, 1'b0, 1'b0, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
